// File: rtl/bbox_tracker_multi.sv
// rtl/bbox_tracker_multi.sv - multi-channel bounding-box tracker with banked per-channel report stream
module bbox_tracker_multi #(
    parameter int N_CH       = 4,
    parameter int HW         = 11,
    parameter int VW         = 10,
    parameter int H_PIXELS   = 960,
    parameter int V_PIXELS   = 640,
    parameter int CNT_W      = 20,
    parameter int MIN_PIXELS = 64,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [HW-1:0]    hcount_in,
    input  logic [VW-1:0]    vcount_in,
    input  logic [N_CH-1:0]  valid_in,
    input  logic             tabulate_in,
    input  logic             ready_in,
    output logic             valid_out,
    output logic [CH_W-1:0]  ch_out,
    output logic [HW-1:0]    x_out,
    output logic [VW-1:0]    y_out,
    output logic [HW-1:0]    w_out,
    output logic [VW-1:0]    h_out,
    output logic [CNT_W-1:0] count_out,
    output logic             found_out,
    output logic             busy_out,
    output logic             overrun_out
);

    typedef enum logic {ACCUM, REPORT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CH_W-1:0]  LAST_IDX = CH_W'(N_CH - 1);

    state_t            state;
    logic [CH_W-1:0]   idx;

    // live accumulators for the frame in progress
    logic [HW-1:0]     min_x [N_CH];
    logic [HW-1:0]     max_x [N_CH];
    logic [VW-1:0]     min_y [N_CH];
    logic [VW-1:0]     max_y [N_CH];
    logic [CNT_W-1:0]  cnt   [N_CH];

    // accumulator values including the current pixel
    logic [HW-1:0]     nx_min_x [N_CH];
    logic [HW-1:0]     nx_max_x [N_CH];
    logic [VW-1:0]     nx_min_y [N_CH];
    logic [VW-1:0]     nx_max_y [N_CH];
    logic [CNT_W-1:0]  nx_cnt   [N_CH];

    // report bank, frozen at tabulate time
    logic [HW-1:0]     b_min_x [N_CH];
    logic [HW-1:0]     b_max_x [N_CH];
    logic [VW-1:0]     b_min_y [N_CH];
    logic [VW-1:0]     b_max_y [N_CH];
    logic [CNT_W-1:0]  b_cnt   [N_CH];

    logic in_active;
    logic cur_found;

    assign in_active = (32'(hcount_in) < H_PIXELS) && (32'(vcount_in) < V_PIXELS);

    // fold the current pixel into each channel's extents and count
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            nx_min_x[c] = min_x[c];
            nx_max_x[c] = max_x[c];
            nx_min_y[c] = min_y[c];
            nx_max_y[c] = max_y[c];
            nx_cnt[c]   = cnt[c];
            if (valid_in[c] && in_active) begin
                if (hcount_in < min_x[c]) nx_min_x[c] = hcount_in;
                if (hcount_in > max_x[c]) nx_max_x[c] = hcount_in;
                if (vcount_in < min_y[c]) nx_min_y[c] = vcount_in;
                if (vcount_in > max_y[c]) nx_max_y[c] = vcount_in;
                if (cnt[c] != CNT_MAX) nx_cnt[c] = cnt[c] + CNT_W'(1);
            end
        end
    end

    // accumulate, bank on tabulate, and step through channels while reporting
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= ACCUM;
            idx         <= '0;
            overrun_out <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                min_x[c]   <= '1;
                max_x[c]   <= '0;
                min_y[c]   <= '1;
                max_y[c]   <= '0;
                cnt[c]     <= '0;
                b_min_x[c] <= '0;
                b_max_x[c] <= '0;
                b_min_y[c] <= '0;
                b_max_y[c] <= '0;
                b_cnt[c]   <= '0;
            end
        end else begin
            overrun_out <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                if (tabulate_in) begin
                    min_x[c] <= '1;
                    max_x[c] <= '0;
                    min_y[c] <= '1;
                    max_y[c] <= '0;
                    cnt[c]   <= '0;
                end else begin
                    min_x[c] <= nx_min_x[c];
                    max_x[c] <= nx_max_x[c];
                    min_y[c] <= nx_min_y[c];
                    max_y[c] <= nx_max_y[c];
                    cnt[c]   <= nx_cnt[c];
                end
            end
            if (tabulate_in && state == ACCUM) begin
                for (int c = 0; c < N_CH; c++) begin
                    b_min_x[c] <= nx_min_x[c];
                    b_max_x[c] <= nx_max_x[c];
                    b_min_y[c] <= nx_min_y[c];
                    b_max_y[c] <= nx_max_y[c];
                    b_cnt[c]   <= nx_cnt[c];
                end
                state <= REPORT;
                idx   <= '0;
            end else if (tabulate_in) begin
                // a report is still draining: this frame is dropped
                overrun_out <= 1'b1;
            end
            if (state == REPORT && ready_in) begin
                if (idx == LAST_IDX) begin
                    state <= ACCUM;
                    idx   <= '0;
                end else begin
                    idx <= idx + CH_W'(1);
                end
            end
        end
    end

    assign cur_found = (32'(b_cnt[idx]) >= MIN_PIXELS);

    // present the banked box for the current channel; blank when not found
    always_comb begin
        valid_out = (state == REPORT);
        busy_out  = (state == REPORT);
        ch_out    = '0;
        x_out     = '0;
        y_out     = '0;
        w_out     = '0;
        h_out     = '0;
        count_out = '0;
        found_out = 1'b0;
        if (state == REPORT) begin
            ch_out    = idx;
            count_out = b_cnt[idx];
            found_out = cur_found;
            if (cur_found) begin
                x_out = b_min_x[idx];
                y_out = b_min_y[idx];
                w_out = b_max_x[idx] - b_min_x[idx] + HW'(1);
                h_out = b_max_y[idx] - b_min_y[idx] + VW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bbox_tracker_multi.sv
// tb/tb_bbox_tracker_multi.sv - randomized and directed self-checking bench for bbox_tracker_multi
module tb_bbox_tracker_multi;

    localparam int N_CH  = 4;
    localparam int HW    = 11;
    localparam int VW    = 10;
    localparam int HPIX  = 960;
    localparam int VPIX  = 640;
    localparam int CNT_W = 12;
    localparam int MINP  = 64;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic [HW-1:0]    hcount_in;
    logic [VW-1:0]    vcount_in;
    logic [N_CH-1:0]  valid_in;
    logic             tabulate_in;
    logic             ready_in;
    logic             valid_out;
    logic [1:0]       ch_out;
    logic [HW-1:0]    x_out;
    logic [VW-1:0]    y_out;
    logic [HW-1:0]    w_out;
    logic [VW-1:0]    h_out;
    logic [CNT_W-1:0] count_out;
    logic             found_out;
    logic             busy_out;
    logic             overrun_out;

    bbox_tracker_multi #(
        .N_CH(N_CH), .HW(HW), .VW(VW), .H_PIXELS(HPIX), .V_PIXELS(VPIX),
        .CNT_W(CNT_W), .MIN_PIXELS(MINP)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .valid_in(valid_in), .tabulate_in(tabulate_in), .ready_in(ready_in),
        .valid_out(valid_out), .ch_out(ch_out), .x_out(x_out), .y_out(y_out),
        .w_out(w_out), .h_out(h_out), .count_out(count_out), .found_out(found_out),
        .busy_out(busy_out), .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // reference model: raw per-frame statistics and the expected report
    int m_mnx[N_CH], m_mxx[N_CH], m_mny[N_CH], m_mxy[N_CH], m_cnt[N_CH];
    int e_x[N_CH], e_y[N_CH], e_w[N_CH], e_h[N_CH], e_cnt[N_CH], e_found[N_CH];
    bit m_busy   = 0;
    bit ovr_pend = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < N_CH; c++) begin
            m_mnx[c] = 1 << 30; m_mxx[c] = -1;
            m_mny[c] = 1 << 30; m_mxy[c] = -1;
            m_cnt[c] = 0;
        end
    endtask

    task automatic model_bank();
        for (int c = 0; c < N_CH; c++) begin
            e_cnt[c]   = (m_cnt[c] > CMAX) ? CMAX : m_cnt[c];
            e_found[c] = (e_cnt[c] >= MINP);
            if (e_found[c] != 0) begin
                e_x[c] = m_mnx[c];
                e_y[c] = m_mny[c];
                e_w[c] = m_mxx[c] - m_mnx[c] + 1;
                e_h[c] = m_mxy[c] - m_mny[c] + 1;
            end else begin
                e_x[c] = 0; e_y[c] = 0; e_w[c] = 0; e_h[c] = 0;
            end
        end
    endtask

    task automatic pix(input logic [N_CH-1:0] m, input int h, input int v, input bit tab);
        @(negedge clk_in);
        chk("overrun", overrun_out, ovr_pend);
        ovr_pend = 0;
        if (m_busy) chk("valid_held", valid_out, 1);
        valid_in    = m;
        hcount_in   = HW'(h);
        vcount_in   = VW'(v);
        tabulate_in = tab;
        ready_in    = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (m[c] && h < HPIX && v < VPIX) begin
                if (h < m_mnx[c]) m_mnx[c] = h;
                if (h > m_mxx[c]) m_mxx[c] = h;
                if (v < m_mny[c]) m_mny[c] = v;
                if (v > m_mxy[c]) m_mxy[c] = v;
                m_cnt[c]++;
            end
        end
        if (tab) begin
            if (m_busy) ovr_pend = 1;
            else begin
                model_bank();
                m_busy = 1;
            end
            model_clear();
        end
    endtask

    task automatic rect(input logic [N_CH-1:0] m, input int x0, input int x1,
                        input int y0, input int y1, input bit tab_last);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                pix(m, x, y, tab_last && x == x1 && y == y1);
    endtask

    task automatic check_box(input int k);
        chk("valid_out", valid_out, 1);
        chk("busy_out", busy_out, 1);
        chk("ch_out", ch_out, k);
        chk("x_out", x_out, e_x[k]);
        chk("y_out", y_out, e_y[k]);
        chk("w_out", w_out, e_w[k]);
        chk("h_out", h_out, e_h[k]);
        chk("count_out", count_out, e_cnt[k]);
        chk("found_out", found_out, e_found[k]);
    endtask

    task automatic drain(input int stall_ch, input int stall_n);
        for (int k = 0; k < N_CH; k++) begin
            for (int s = 0; s < ((k == stall_ch) ? stall_n : 0); s++) begin
                @(negedge clk_in);
                chk("overrun", overrun_out, ovr_pend);
                ovr_pend = 0;
                valid_in = '0; tabulate_in = 1'b0; ready_in = 1'b0;
                check_box(k);
            end
            @(negedge clk_in);
            chk("overrun", overrun_out, ovr_pend);
            ovr_pend = 0;
            valid_in = '0; tabulate_in = 1'b0; ready_in = 1'b1;
            check_box(k);
        end
        @(negedge clk_in);
        ready_in = 1'b0;
        chk("valid_after", valid_out, 0);
        chk("busy_after", busy_out, 0);
        m_busy = 0;
    endtask

    initial begin
        rst_n_in = 1'b0; hcount_in = '0; vcount_in = '0; valid_in = '0;
        tabulate_in = 1'b0; ready_in = 1'b0;
        model_clear();
        repeat (3) @(negedge clk_in);
        chk("rst_valid", valid_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_overrun", overrun_out, 0);
        chk("rst_count", count_out, 0);
        chk("rst_x", x_out, 0);
        rst_n_in = 1'b1;

        // single rectangle on ch0
        rect(4'b0001, 100, 199, 50, 89, 1);
        drain(-1, 0);

        // 10-pixel noise blob on ch2, tabulate on an empty pixel
        for (int i = 0; i < 10; i++) pix(4'b0100, 300 + (i % 2), 200 + i / 2, 0);
        pix(4'b0000, 0, 0, 1);
        drain(-1, 0);

        // two frames back to back; tabulate-cycle pixel belongs to frame 1
        rect(4'b0011, 10, 29, 10, 19, 0);
        pix(4'b0010, 900, 600, 1);
        drain(-1, 0);
        rect(4'b0010, 500, 519, 300, 309, 1);
        drain(1, 5);

        // tabulate while busy: frame dropped, report intact
        rect(4'b0101, 40, 59, 40, 49, 1);
        rect(4'b1111, 0, 9, 0, 9, 0);
        pix(4'b1000, 5, 5, 1);
        pix(4'b0001, 700, 400, 0);
        drain(2, 2);
        rect(4'b1000, 600, 619, 100, 109, 1);
        drain(-1, 0);

        // active-area edges and counter saturation
        rect(4'b1001, 896, 959, 576, 639, 0);
        pix(4'b1111, 960, 600, 0);
        pix(4'b1111, 900, 640, 0);
        pix(4'b0110, 1000, 700, 1);
        drain(3, 1);

        // randomized frames
        for (int f = 0; f < 12; f++) begin
            int n;
            n = $urandom_range(40, 200);
            for (int i = 0; i < n; i++)
                pix(N_CH'($urandom_range(0, 15)), $urandom_range(0, 1023),
                    $urandom_range(0, 700), i == n - 1);
            if (f % 4 == 3) begin
                pix(4'b0001, 1, 1, 1);
                pix(4'b0000, 0, 0, 0);
            end
            drain($urandom_range(0, 3), $urandom_range(0, 3));
        end

        // reset in the middle of a report
        rect(4'b0001, 10, 19, 10, 19, 1);
        @(negedge clk_in);
        valid_in = '0; tabulate_in = 1'b0;
        chk("pre_rst_valid", valid_out, 1);
        #2 rst_n_in = 1'b0;
        #1;
        chk("async_rst_valid", valid_out, 0);
        chk("async_rst_busy", busy_out, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        m_busy = 0; ovr_pend = 0;
        model_clear();
        @(negedge clk_in);
        chk("post_rst_valid", valid_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
